// File: rtl/e200_itcm_loader_pkg.sv
// Shared types and constants for the ITCM image loader: FSM encoding,
// ITCM word/mask widths and the default ITCM depth.
package e200_itcm_loader_pkg;

  localparam int E200_ITCM_RAM_DP = 16384;
  localparam int ITCM_DW          = 64;
  localparam int ITCM_MW          = 8;
  localparam int ITCM_LANES       = ITCM_MW;
  localparam int LANE_W           = 3;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_DONE = 2'd2,
    LDR_ERR  = 2'd3
  } ldr_state_e;

  typedef logic [ITCM_DW-1:0] itcm_word_t;
  typedef logic [ITCM_MW-1:0] itcm_mask_t;

  function automatic itcm_mask_t lane_bit(input logic [LANE_W-1:0] lane);
    return itcm_mask_t'(1) << lane;
  endfunction

endpackage

// File: rtl/e200_itcm_loader_if.sv
// Byte-stream handshake plus ITCM RAM write port, bundled for the loader.
// slave = loader side, master = stream source / RAM side.
interface e200_itcm_loader_if
  import e200_itcm_loader_pkg::*;
#(
  parameter int ITCM_AW = 14
) ();

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_last;
  logic               byte_ready;

  logic               itcm_cs;
  logic               itcm_we;
  itcm_mask_t         itcm_wem;
  logic [ITCM_AW-1:0] itcm_addr;
  itcm_word_t         itcm_din;

  modport slave (
    input  byte_valid, byte_data, byte_last,
    output byte_ready,
    output itcm_cs, itcm_we, itcm_wem, itcm_addr, itcm_din
  );

  modport master (
    output byte_valid, byte_data, byte_last,
    input  byte_ready,
    input  itcm_cs, itcm_we, itcm_wem, itcm_addr, itcm_din
  );

endinterface

// File: rtl/e200_itcm_loader_pack.sv
// 8-lane little-endian byte packer. word/mask/cmpl are combinational and
// already include the byte accepted this cycle.
module e200_itcm_loader_pack
  import e200_itcm_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       acc,
  input  logic [7:0] data,
  input  logic       last,
  output itcm_word_t word,
  output itcm_mask_t mask,
  output logic       cmpl
);

  logic [ITCM_LANES-1:0][7:0] pk_q;
  logic [ITCM_LANES-1:0][7:0] pk_nx;
  itcm_mask_t                 msk_q;
  logic [LANE_W-1:0]          lane_idx;

  assign cmpl = acc && ((lane_idx == LANE_W'(ITCM_LANES-1)) || last);

  always_comb begin
    pk_nx = pk_q;
    if (acc) pk_nx[lane_idx] = data;
  end

  assign word = pk_nx;
  assign mask = msk_q | (acc ? lane_bit(lane_idx) : '0);

  // A completed word leaves the packer through the top's output registers,
  // so the buffer restarts empty at lane 0 on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clr || cmpl) begin
      pk_q     <= '0;
      msk_q    <= '0;
      lane_idx <= '0;
    end else if (acc) begin
      pk_q[lane_idx]  <= data;
      msk_q[lane_idx] <= 1'b1;
      lane_idx        <= lane_idx + LANE_W'(1);
    end
  end

endmodule

// File: rtl/e200_itcm_loader.sv
// ITCM image loader: packs a byte stream into 64-bit ITCM writes from
// address 0 and holds the core in reset until the image is in.
// Optional running byte checksum output: define E200_ITCM_LOADER_CHKSUM_EN.
module e200_itcm_loader
  import e200_itcm_loader_pkg::*;
#(
  parameter int ITCM_DP = E200_ITCM_RAM_DP,
  parameter int ITCM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  e200_itcm_loader_if.slave  bus,
  output logic               core_rst_hold,
  output logic               done,
  output logic               error,
  output logic [ITCM_AW:0]   word_cnt
`ifdef E200_ITCM_LOADER_CHKSUM_EN
  ,
  output logic [31:0]        chksum
`endif
);

  localparam logic [ITCM_AW:0] ADDR_END = (ITCM_AW+1)'(ITCM_DP);

  ldr_state_e       state_q, state_d;
  logic [ITCM_AW:0] addr_q;
  logic             full, acc, clr, wr;
  itcm_word_t       pk_word;
  itcm_mask_t       pk_mask;

  // One bit wider than the RAM address so "one past the end" is representable.
  assign full = (addr_q == ADDR_END);
  assign acc  = bus.byte_valid && bus.byte_ready;
  assign clr  = start && (state_q != LDR_LOAD);

  e200_itcm_loader_pack u_pack (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .acc  (acc),
    .data (bus.byte_data),
    .last (bus.byte_last),
    .word (pk_word),
    .mask (pk_mask),
    .cmpl (wr)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= LDR_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_IDLE: if (start) state_d = LDR_LOAD;
      LDR_LOAD: begin
        if (bus.byte_valid && full)          state_d = LDR_ERR;
        else if (acc && bus.byte_last)       state_d = LDR_DONE;
      end
      LDR_DONE: if (start) state_d = LDR_LOAD;
      LDR_ERR:  if (start) state_d = LDR_LOAD;
      default:             state_d = LDR_IDLE;
    endcase
  end

  always_comb begin
    bus.byte_ready = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    core_rst_hold  = 1'b1;
    case (state_q)
      LDR_LOAD: bus.byte_ready = !full;
      LDR_DONE: begin
        done          = 1'b1;
        core_rst_hold = 1'b0;
      end
      LDR_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.itcm_cs   <= 1'b0;
      bus.itcm_we   <= 1'b0;
      bus.itcm_wem  <= '0;
      bus.itcm_addr <= '0;
      bus.itcm_din  <= '0;
      addr_q        <= '0;
      word_cnt      <= '0;
    end else begin
      bus.itcm_cs <= wr;
      bus.itcm_we <= wr;
      if (clr) begin
        addr_q   <= '0;
        word_cnt <= '0;
      end else if (wr) begin
        bus.itcm_addr <= addr_q[ITCM_AW-1:0];
        bus.itcm_din  <= pk_word;
        bus.itcm_wem  <= pk_mask;
        addr_q        <= addr_q + 1'b1;
        word_cnt      <= word_cnt + 1'b1;
      end
    end
  end

`ifdef E200_ITCM_LOADER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || clr) chksum <= '0;
    else if (acc)   chksum <= chksum + {24'd0, bus.byte_data};
  end
`endif

endmodule

// File: doc/e200_itcm_loader.md
# e200_itcm_loader

Synthesizable ITCM image loader sitting directly upstream of the e200 core's ITCM SRAM in simulation and FPGA bring-up builds. It accepts a little-endian byte stream over a valid/ready handshake, packs bytes into 64-bit ITCM words, writes them through the ITCM RAM write port from address 0 upward, and holds the core in reset until the image is fully written. It replaces backdoor memory preloading so the same image path works in both RTL simulation and on the board.

## Interface

Parameters:
- `ITCM_DP`, 16384: ITCM depth in 64-bit words; must equal `E200_ITCM_RAM_DP`.
- `ITCM_AW`, 14: ITCM word-address width; equals clog2(`ITCM_DP`).

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load at word address 0.
- `byte_valid`  in  1  stream byte present.
- `byte_data`  in  8  stream byte.
- `byte_last`  in  1  qualifies the final byte of the image; meaningful only with `byte_valid`.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `itcm_cs`  out  1  ITCM chip select, one-cycle write pulse.
- `itcm_we`  out  1  ITCM write enable; always equal to `itcm_cs`.
- `itcm_wem`  out  8  per-byte write mask; bit i covers `itcm_din[8i+7:8i]`.
- `itcm_addr`  out  `ITCM_AW`  ITCM word address.
- `itcm_din`  out  64  ITCM write data.
- `core_rst_hold`  out  1  keeps the core in reset while high.
- `done`  out  1  image fully written.
- `error`  out  1  sticky overflow flag.
- `word_cnt`  out  `ITCM_AW`+1  number of ITCM writes issued in the current load.

## Operation

- States: IDLE, LOAD, DONE, ERR.
- IDLE: `byte_ready`=0. On `start`, go to LOAD. Lane index, address, `word_cnt` and pack buffer all clear.
- LOAD: `byte_ready`=1 unless an overflow is pending. An accepted byte (valid & ready) is stored in lane `lane_idx` of the pack buffer, and its mask bit is set. `lane_idx` is 3 bits and wraps 7→0.
- A word completes when a byte is accepted at lane 7, or a byte is accepted with `byte_last`. Completion has these effects:
  - The output registers load the assembled word, including the current byte, plus its mask.
  - `itcm_cs`/`itcm_we` pulse for exactly one cycle.
  - The buffer and mask clear.
  - The address increments after the write.
  - `word_cnt` increments.
- Unwritten lanes of a partial final word have their mask bits at 0 and their data at 0.
- After accepting the `byte_last` byte, go to DONE.
- Overflow: a byte arriving when the address has already reached `ITCM_DP` (the address counter is `ITCM_AW`+1 wide internally) goes to ERR. That byte is not accepted and no write is issued.
- DONE: `done`=1, `core_rst_hold`=0, `byte_ready`=0.
- ERR: `error`=1, `core_rst_hold`=1, `byte_ready`=0.
- `start` in LOAD is ignored. `start` in DONE or ERR clears `done`/`error`, reasserts `core_rst_hold`, and restarts LOAD at address 0.
- `core_rst_hold` is 1 in IDLE, LOAD and ERR.

## Timing

- Reset values of outputs: `byte_ready`=0, `itcm_cs`=0, `itcm_we`=0, `itcm_wem`=0, `itcm_addr`=0, `itcm_din`=0, `core_rst_hold`=1, `done`=0, `error`=0, `word_cnt`=0. Internal state resets to IDLE.
- Write latency: the ITCM write pulse is asserted in the cycle after the completing byte handshake.
- Throughput: one byte per cycle sustained. `byte_ready` does not drop during writes.
- `done` rises in the same cycle as the final write pulse. `core_rst_hold` falls in that same cycle.
- Simultaneous lane 7 and `byte_last` produce a single write with `itcm_wem`=8'hFF.
- `byte_last` at lane 0 produces a write with `itcm_wem`=8'h01.
- `rst` mid-load aborts immediately to IDLE: no write in the following cycle, and the partial buffer is discarded.
- `byte_valid` low inserts bubbles; lane and address hold.

## Configuration

- `E200_ITCM_LOADER_CHKSUM_EN` defined:
  - Adds output `chksum`[31:0]: the modulo-2^32 sum of all accepted bytes (zero-extended) since the last `start`.
  - It updates in the cycle after each handshake and resets to 0 on `rst` or `start`.
- Undefined: port and adder absent. All other behaviour is identical.

## Structure

- Shared package or defines holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2, ERR=2'd3);
  - the 64-bit word and 8-bit mask widths;
  - the `E200_ITCM_RAM_DP`-derived depth constant.
- One sub-module: `e200_itcm_loader_pack`. It covers the 8-lane byte packer with mask and lane counter, and emits the completed word, mask and complete strobe.
- The FSM, address/`word_cnt` counters and output registers live in the top module.

## Test plan

- Reset then `start`, then 16 bytes 0x00..0x0F at 1/cycle with last on 0x0F:
  - two writes: addr 0 with din 64'h0706050403020100, and addr 1 with din 64'h0F0E0D0C0B0A0908;
  - both with wem 8'hFF;
  - `done`=1 and `core_rst_hold`=0 in the second write cycle;
  - `word_cnt`=2.
- 9 bytes 0xA0..0xA8 with last on 0xA8: second write at addr 1 with wem 8'h01 and din 64'h00000000000000A8.
- Random `byte_valid` bubbles on a 24-byte image: the three writes match the contiguous case and addresses are 0, 1, 2.
- `ITCM_DP`=4, 40 bytes offered:
  - four full writes;
  - the 33rd byte is not accepted;
  - `error`=1, `core_rst_hold`=1, `byte_ready`=0.
- `rst` asserted after 5 bytes: no write occurs; then `start` plus 8 bytes 0x11 gives a single write at addr 0 with din 64'h1111111111111111.
- With `E200_ITCM_LOADER_CHKSUM_EN`, bytes 0xFF×4 with last: `chksum`=32'h000003FC and one write with wem 8'h0F.
